// File: rtl/layer4_out_buffer.sv
// Ping-pong frame buffer between the layer-4 ReLU outputs and the layer-5 x input.
// Optional status outputs (err_o, frame_cnt_o) are built when OBUF_STATUS_EN is defined.
module layer4_out_buffer #(
  parameter int DATA_W = 8,
  parameter int LANES  = 32,
  localparam int ADDR_W = $clog2(2 * LANES)
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    wr_lo_i,
  input  logic                    wr_hi_i,
  input  logic [LANES*DATA_W-1:0] wr_data_i,
  input  logic                    rd_en_i,
  input  logic [ADDR_W-1:0]       rd_addr_i,
  input  logic                    rd_done_i,
  output logic [DATA_W-1:0]       rd_data_o,
  output logic                    rd_valid_o,
  output logic                    frame_rdy_o,
  output logic                    full_o
`ifdef OBUF_STATUS_EN
  ,
  output logic                    err_o,
  output logic [15:0]             frame_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } status_e;

  status_e status_q [2];
  status_e status_d [2];
  logic    wr_sel_q, wr_sel_d;
  logic    rd_sel_q, rd_sel_d;
  logic    full_q, full_d;
  logic    frame_rdy_q, frame_rdy_d;
  logic    rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;

  logic wr_lo_en;
  logic wr_hi_en;
  logic err_evt;
  logic done_acc;

  logic [DATA_W-1:0] wr_lane [LANES];
  logic [DATA_W-1:0] mem [2][2*LANES];

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    assign wr_lane[gi] = wr_data_i[gi*DATA_W +: DATA_W];
  end

  always_comb begin
    status_d    = status_q;
    wr_sel_d    = wr_sel_q;
    rd_sel_d    = rd_sel_q;
    wr_lo_en    = 1'b0;
    wr_hi_en    = 1'b0;
    err_evt     = 1'b0;
    done_acc    = 1'b0;
    rd_valid_d  = rd_en_i;
    rd_data_d   = rd_data_q;

    // full_q is consistent with status_q[wr_sel_q], so the write bank is never FULL here
    if (wr_lo_i || wr_hi_i) begin
      if (full_q) begin
        err_evt = 1'b1;
      end else if (wr_lo_i && wr_hi_i) begin
        wr_lo_en           = 1'b1;
        wr_hi_en           = 1'b1;
        status_d[wr_sel_q] = ST_FULL;
        wr_sel_d           = ~wr_sel_q;
      end else if (wr_lo_i) begin
        wr_lo_en           = 1'b1;
        status_d[wr_sel_q] = ST_HALF;
      end else if (status_q[wr_sel_q] == ST_HALF) begin
        wr_hi_en           = 1'b1;
        status_d[wr_sel_q] = ST_FULL;
        wr_sel_d           = ~wr_sel_q;
      end else begin
        err_evt = 1'b1;
      end
    end

    if (rd_done_i && frame_rdy_q) begin
      done_acc           = 1'b1;
      status_d[rd_sel_q] = ST_EMPTY;
      rd_sel_d           = ~rd_sel_q;
    end

    // Derived from next-state so a simultaneous complete+release never flashes full
    full_d      = (status_d[wr_sel_d] == ST_FULL);
    frame_rdy_d = (status_d[rd_sel_d] == ST_FULL);

    if (rd_en_i) begin
      rd_data_d = frame_rdy_q ? mem[rd_sel_q][rd_addr_i] : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      status_q[0] <= ST_EMPTY;
      status_q[1] <= ST_EMPTY;
      wr_sel_q    <= 1'b0;
      rd_sel_q    <= 1'b0;
      full_q      <= 1'b0;
      frame_rdy_q <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
    end else begin
      status_q[0] <= status_d[0];
      status_q[1] <= status_d[1];
      wr_sel_q    <= wr_sel_d;
      rd_sel_q    <= rd_sel_d;
      full_q      <= full_d;
      frame_rdy_q <= frame_rdy_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
    end
  end

  // Frame storage survives reset; only the bank bookkeeping is cleared
  always_ff @(posedge clk_i) begin
    if (wr_lo_en) begin
      for (int k = 0; k < LANES; k++) begin
        mem[wr_sel_q][k] <= wr_lane[k];
      end
    end
    if (wr_hi_en) begin
      for (int k = 0; k < LANES; k++) begin
        mem[wr_sel_q][LANES + k] <= wr_lane[k];
      end
    end
  end

  assign rd_data_o   = rd_data_q;
  assign rd_valid_o  = rd_valid_q;
  assign frame_rdy_o = frame_rdy_q;
  assign full_o      = full_q;

`ifdef OBUF_STATUS_EN
  logic        err_q, err_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    err_d       = err_q | err_evt;
    frame_cnt_d = done_acc ? frame_cnt_q + 16'd1 : frame_cnt_q;
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      err_q       <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      err_q       <= err_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign err_o       = err_q;
  assign frame_cnt_o = frame_cnt_q;
`else
  logic unused_status;
  assign unused_status = err_evt ^ done_acc;
`endif

endmodule

// File: tb/tb_layer4_out_buffer.sv
// Directed bench for layer4_out_buffer: fill/read/release sequences with hand-computed results.
// Status outputs are checked only when OBUF_STATUS_EN is defined.
module tb_layer4_out_buffer;

  localparam int DATA_W = 8;
  localparam int LANES  = 32;

  logic                    clk_i = 1'b0;
  logic                    rstn_i;
  logic                    wr_lo_i;
  logic                    wr_hi_i;
  logic [LANES*DATA_W-1:0] wr_data_i;
  logic                    rd_en_i;
  logic [5:0]              rd_addr_i;
  logic                    rd_done_i;
  logic [DATA_W-1:0]       rd_data_o;
  logic                    rd_valid_o;
  logic                    frame_rdy_o;
  logic                    full_o;
`ifdef OBUF_STATUS_EN
  logic                    err_o;
  logic [15:0]             frame_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk_i = ~clk_i;

  layer4_out_buffer #(.DATA_W(DATA_W), .LANES(LANES)) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .wr_lo_i     (wr_lo_i),
    .wr_hi_i     (wr_hi_i),
    .wr_data_i   (wr_data_i),
    .rd_en_i     (rd_en_i),
    .rd_addr_i   (rd_addr_i),
    .rd_done_i   (rd_done_i),
    .rd_data_o   (rd_data_o),
    .rd_valid_o  (rd_valid_o),
    .frame_rdy_o (frame_rdy_o),
    .full_o      (full_o)
`ifdef OBUF_STATUS_EN
    ,
    .err_o       (err_o),
    .frame_cnt_o (frame_cnt_o)
`endif
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one write cycle; lane k carries base + step*k
  task automatic wr(input logic lo, input logic hi, input int base, input int step);
    for (int k = 0; k < LANES; k++) begin
      wr_data_i[k*DATA_W +: DATA_W] = 8'(base + step * k);
    end
    wr_lo_i = lo;
    wr_hi_i = hi;
    tick();
    wr_lo_i = 1'b0;
    wr_hi_i = 1'b0;
  endtask

  task automatic rd(input int addr, input logic done);
    rd_en_i   = 1'b1;
    rd_addr_i = 6'(addr);
    rd_done_i = done;
    tick();
    rd_en_i   = 1'b0;
    rd_done_i = 1'b0;
  endtask

  task automatic pulse_done();
    rd_done_i = 1'b1;
    tick();
    rd_done_i = 1'b0;
  endtask

  initial begin
    rstn_i    = 1'b0;
    wr_lo_i   = 1'b0;
    wr_hi_i   = 1'b0;
    wr_data_i = '0;
    rd_en_i   = 1'b0;
    rd_addr_i = '0;
    rd_done_i = 1'b0;
    repeat (3) tick();
    chk("rst_data", 32'(rd_data_o), 32'h0);
    chk("rst_valid", 32'(rd_valid_o), 32'h0);
    chk("rst_rdy", 32'(frame_rdy_o), 32'h0);
    chk("rst_full", 32'(full_o), 32'h0);
    rstn_i = 1'b1;
    tick();

    // Frame in bank0: lower lanes k, upper lanes 0x80+k
    wr(1'b1, 1'b0, 0, 1);
    chk("half_rdy", 32'(frame_rdy_o), 32'h0);
    wr(1'b0, 1'b1, 8'h80, 1);
    chk("f0_rdy", 32'(frame_rdy_o), 32'h1);
    chk("f0_full", 32'(full_o), 32'h0);
    for (int a = 0; a < 64; a++) begin
      rd(a, 1'b0);
      chk("f0_valid", 32'(rd_valid_o), 32'h1);
      chk($sformatf("f0_data[%0d]", a), 32'(rd_data_o), (a < 32) ? 32'(a) : 32'(8'h80 + a - 32));
    end
    tick();
    chk("idle_valid", 32'(rd_valid_o), 32'h0);
    chk("idle_hold", 32'(rd_data_o), 32'h9F);

    // Bank1: 0x40+k / 0xC0+k, then an overflow write of 0xFF
    wr(1'b1, 1'b0, 8'h40, 1);
    wr(1'b0, 1'b1, 8'hC0, 1);
    chk("both_full", 32'(full_o), 32'h1);
    chk("both_rdy", 32'(frame_rdy_o), 32'h1);
    wr(1'b1, 1'b0, 8'hFF, 0);
    chk("drop_full", 32'(full_o), 32'h1);
`ifdef OBUF_STATUS_EN
    chk("drop_err", 32'(err_o), 32'h1);
`endif
    rd(5, 1'b0);
    chk("drop_rd5", 32'(rd_data_o), 32'h05);
    rd(37, 1'b0);
    chk("drop_rd37", 32'(rd_data_o), 32'h85);

    // Release bank0 while bank1 is full
    pulse_done();
    chk("rel0_rdy", 32'(frame_rdy_o), 32'h1);
    chk("rel0_full", 32'(full_o), 32'h0);
`ifdef OBUF_STATUS_EN
    chk("rel0_cnt", 32'(frame_cnt_o), 32'h1);
`endif
    rd(5, 1'b0);
    chk("b1_rd5", 32'(rd_data_o), 32'h45);
    rd(40, 1'b0);
    chk("b1_rd40", 32'(rd_data_o), 32'hC8);

    // Release bank1, then wr_hi into an empty bank
    pulse_done();
    chk("rel1_rdy", 32'(frame_rdy_o), 32'h0);
    wr(1'b0, 1'b1, 8'h77, 0);
    chk("hiempty_rdy", 32'(frame_rdy_o), 32'h0);
    chk("hiempty_full", 32'(full_o), 32'h0);
`ifdef OBUF_STATUS_EN
    chk("hiempty_err", 32'(err_o), 32'h1);
    chk("rel1_cnt", 32'(frame_cnt_o), 32'h2);
`endif
    rd(3, 1'b0);
    chk("norflag_valid", 32'(rd_valid_o), 32'h1);
    chk("norflag_data", 32'(rd_data_o), 32'h0);

    // Bank0 full; bank1 completes on the same cycle bank0 is released
    wr(1'b1, 1'b0, 8'h10, 1);
    wr(1'b0, 1'b1, 8'h20, 1);
    chk("b0b_rdy", 32'(frame_rdy_o), 32'h1);
    wr(1'b1, 1'b0, 8'h30, 1);
    rd_done_i = 1'b1;
    wr(1'b0, 1'b1, 8'h50, 1);
    rd_done_i = 1'b0;
    chk("same_rdy", 32'(frame_rdy_o), 32'h1);
    chk("same_full", 32'(full_o), 32'h0);
`ifdef OBUF_STATUS_EN
    chk("same_cnt", 32'(frame_cnt_o), 32'h3);
`endif
    tick();
    chk("same_full2", 32'(full_o), 32'h0);
    rd(40, 1'b0);
    chk("same_rd40", 32'(rd_data_o), 32'h58);
    rd(2, 1'b0);
    chk("same_rd2", 32'(rd_data_o), 32'h32);
    rd(33, 1'b1);
    chk("rddone_data", 32'(rd_data_o), 32'h51);
    chk("rddone_rdy", 32'(frame_rdy_o), 32'h0);
`ifdef OBUF_STATUS_EN
    chk("rddone_cnt", 32'(frame_cnt_o), 32'h4);
`endif

    // Reset mid-frame, after a lower-half write only
    wr(1'b1, 1'b0, 8'hA0, 1);
    rstn_i = 1'b0;
    #1;
    chk("mrst_data", 32'(rd_data_o), 32'h0);
    chk("mrst_valid", 32'(rd_valid_o), 32'h0);
    chk("mrst_rdy", 32'(frame_rdy_o), 32'h0);
    chk("mrst_full", 32'(full_o), 32'h0);
`ifdef OBUF_STATUS_EN
    chk("mrst_err", 32'(err_o), 32'h0);
    chk("mrst_cnt", 32'(frame_cnt_o), 32'h0);
`endif
    tick();
    rstn_i = 1'b1;
    tick();
    rd(7, 1'b0);
    chk("post_valid", 32'(rd_valid_o), 32'h1);
    chk("post_data", 32'(rd_data_o), 32'h0);
    wr(1'b1, 1'b1, 8'h60, 1);
    chk("both_rdy2", 32'(frame_rdy_o), 32'h1);
    chk("both_full2", 32'(full_o), 32'h0);
    rd(0, 1'b0);
    chk("post_rd0", 32'(rd_data_o), 32'h60);
    rd(63, 1'b0);
    chk("post_rd63", 32'(rd_data_o), 32'h7F);
    rd(32, 1'b0);
    chk("post_rd32", 32'(rd_data_o), 32'h60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
